// File: rtl/data_store_buffer.sv
// Posted-write store buffer between the MIPS M stage and data RAM.
// Stores retire into a FIFO drained in the background; loads forward from the youngest match or stall on a miss.
module data_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        empty,
  output logic        full,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ready,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} stateT;

  stateT         state, stateNext;
  logic [29:0]   entryAddr [DEPTH];
  logic [31:0]   entryData [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic          isLoad, hit, loadMiss, enq, pop, rdDone;
  logic [31:0]   hitData;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^cpu_addr[1:0];

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign isLoad   = cpu_ren & ~cpu_wen;
  assign loadMiss = isLoad & ~hit;
  assign enq      = cpu_wen & ~full;
  assign rdDone   = (state == RD_WAIT) & ram_rvalid;

  // Scan oldest to youngest so the last match wins; slots beyond count are stale.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (entryAddr[idx] == cpu_addr[31:2])) begin
        hit     = 1'b1;
        hitData = entryData[idx];
      end
    end
  end

  always_comb begin
    stateNext = state;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (loadMiss)
          stateNext = RD_REQ;
        else if (!empty)
          stateNext = WR_REQ;
      end
      WR_REQ: begin
        ram_req   = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {entryAddr[head], 2'b00};
        ram_wdata = entryData[head];
        if (ram_ready) begin
          pop       = 1'b1;
          stateNext = IDLE;
        end
      end
      RD_REQ: begin
        ram_req  = 1'b1;
        ram_addr = {cpu_addr[31:2], 2'b00};
        if (ram_ready)
          stateNext = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_rvalid)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // CPU-facing outputs are forced quiet while reset is asserted so they settle immediately.
  always_comb begin
    stall     = 1'b0;
    cpu_rdata = '0;
    if (!rst) begin
      stall = (cpu_wen & full) | (loadMiss & ~rdDone);
      if (isLoad && hit)
        cpu_rdata = hitData;
      else if (isLoad && rdDone)
        cpu_rdata = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= stateNext;
      if (enq)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entryAddr[tail] <= cpu_addr[31:2];
      entryData[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Directed self-checking bench for data_store_buffer (DEPTH=4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_data_store_buffer;

  logic        clk;
  logic        rst;
  logic        cpu_wen;
  logic        cpu_ren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        empty;
  logic        full;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ready;
  logic        ram_rvalid;
  logic [31:0] ram_rdata;

  int total;
  int bad;

  data_store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_wen    (cpu_wen),
    .cpu_ren    (cpu_ren),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .empty      (empty),
    .full       (full),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ready  (ram_ready),
    .ram_rvalid (ram_rvalid),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setCpu(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [31:0] wdata);
    cpu_wen   = wen;
    cpu_ren   = ren;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic waitEmpty(input string tag);
    int n;
    n = 0;
    while (empty !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(empty), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    setCpu(1'b0, 1'b0, 32'h0, 32'h0);
    ram_ready  = 1'b0;
    ram_rvalid = 1'b0;
    ram_rdata  = 32'h0;

    // reset state
    @(negedge clk); #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_req", 32'(ram_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // two stores then in-order drain with ram_ready tied high
    ram_ready = 1'b1;
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h10, 32'hAAAA0001); #1;
    chk("seq_st0_stall", 32'(stall), 32'd0);
    chk("seq_st0_req", 32'(ram_req), 32'd0);
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h14, 32'h0000BEEF); #1;
    chk("seq_st1_stall", 32'(stall), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("seq_wr0_req", 32'(ram_req), 32'd1);
    chk("seq_wr0_we", 32'(ram_we), 32'd1);
    chk("seq_wr0_addr", ram_addr, 32'h10);
    chk("seq_wr0_data", ram_wdata, 32'hAAAA0001);
    @(negedge clk); #1;
    chk("seq_gap_req", 32'(ram_req), 32'd0);
    chk("seq_gap_empty", 32'(empty), 32'd0);
    @(negedge clk); #1;
    chk("seq_wr1_req", 32'(ram_req), 32'd1);
    chk("seq_wr1_addr", ram_addr, 32'h14);
    chk("seq_wr1_data", ram_wdata, 32'h0000BEEF);
    @(negedge clk); #1;
    chk("seq_empty", 32'(empty), 32'd1);

    // forwarding from the youngest duplicate
    ram_ready = 1'b0;
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h20, 32'h1); #1;
    chk("fwd_st0_stall", 32'(stall), 32'd0);
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h20, 32'h2); #1;
    chk("fwd_st1_stall", 32'(stall), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b1, 32'h22, 32'h0); #1;
    chk("fwd_rdata", cpu_rdata, 32'h2);
    chk("fwd_stall", 32'(stall), 32'd0);
    chk("fwd_we", 32'(ram_we), 32'd1);
    chk("fwd_addr", ram_addr, 32'h20);
    @(negedge clk); setCpu(1'b0, 1'b0, 32'h0, 32'h0); ram_ready = 1'b1; #1;
    chk("fwd_hold_addr", ram_addr, 32'h20);
    chk("fwd_hold_data", ram_wdata, 32'h1);
    chk("fwd_idle_rdata", cpu_rdata, 32'h0);
    waitEmpty("fwd_drain");

    // load miss from an empty buffer
    @(negedge clk); setCpu(1'b0, 1'b1, 32'h40, 32'h0); #1;
    chk("miss_c0_stall", 32'(stall), 32'd1);
    chk("miss_c0_req", 32'(ram_req), 32'd0);
    @(negedge clk); #1;
    chk("miss_c1_stall", 32'(stall), 32'd1);
    chk("miss_c1_req", 32'(ram_req), 32'd1);
    chk("miss_c1_we", 32'(ram_we), 32'd0);
    chk("miss_c1_addr", ram_addr, 32'h40);
    @(negedge clk); ram_rvalid = 1'b1; ram_rdata = 32'h12345678; #1;
    chk("miss_c2_stall", 32'(stall), 32'd0);
    chk("miss_c2_rdata", cpu_rdata, 32'h12345678);
    chk("miss_c2_req", 32'(ram_req), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b0, 32'h0, 32'h0); ram_rvalid = 1'b0; ram_rdata = 32'h0; #1;
    chk("miss_after_rdata", cpu_rdata, 32'h0);
    chk("miss_after_stall", 32'(stall), 32'd0);

    // fill to DEPTH, fifth store waits for a pop
    ram_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); setCpu(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h11 * 32'(k + 1)); #1;
      chk("full_fill_stall", 32'(stall), 32'd0);
    end
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h110, 32'h55); #1;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_head_addr", ram_addr, 32'h100);
    @(negedge clk); ram_ready = 1'b1; #1;
    chk("full_pop_stall", 32'(stall), 32'd1);
    chk("full_pop_flag", 32'(full), 32'd1);
    @(negedge clk); ram_ready = 1'b0; #1;
    chk("full_enq_flag", 32'(full), 32'd0);
    chk("full_enq_stall", 32'(stall), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b0, 32'h0, 32'h0); ram_ready = 1'b1; #1;
    chk("full_refill", 32'(full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        @(negedge clk); #1;
        chk("full_drain_gap", 32'(ram_req), 32'd0);
        @(negedge clk); #1;
      end
      chk("full_drain_req", 32'(ram_req), 32'd1);
      chk("full_drain_addr", ram_addr, 32'h104 + 32'(4 * k));
      chk("full_drain_data", ram_wdata, 32'h11 * 32'(k + 2));
    end
    @(negedge clk); #1;
    chk("full_drain_empty", 32'(empty), 32'd1);

    // load miss arriving while a write is outstanding
    ram_ready = 1'b0;
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h50, 32'h5050); #1;
    chk("mbd_st_stall", 32'(stall), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
    chk("mbd_idle_req", 32'(ram_req), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b1, 32'h60, 32'h0); #1;
    chk("mbd_w0_stall", 32'(stall), 32'd1);
    chk("mbd_w0_we", 32'(ram_we), 32'd1);
    chk("mbd_w0_addr", ram_addr, 32'h50);
    @(negedge clk); #1;
    chk("mbd_w1_stall", 32'(stall), 32'd1);
    chk("mbd_w1_addr", ram_addr, 32'h50);
    @(negedge clk); ram_ready = 1'b1; #1;
    chk("mbd_acc_stall", 32'(stall), 32'd1);
    chk("mbd_acc_we", 32'(ram_we), 32'd1);
    chk("mbd_acc_data", ram_wdata, 32'h5050);
    @(negedge clk); #1;
    chk("mbd_idle_stall", 32'(stall), 32'd1);
    chk("mbd_idle2_req", 32'(ram_req), 32'd0);
    chk("mbd_idle_empty", 32'(empty), 32'd1);
    @(negedge clk); #1;
    chk("mbd_rd_req", 32'(ram_req), 32'd1);
    chk("mbd_rd_we", 32'(ram_we), 32'd0);
    chk("mbd_rd_addr", ram_addr, 32'h60);
    chk("mbd_rd_stall", 32'(stall), 32'd1);
    @(negedge clk); ram_ready = 1'b0; #1;
    chk("mbd_wait_req", 32'(ram_req), 32'd0);
    chk("mbd_wait_stall", 32'(stall), 32'd1);
    @(negedge clk); ram_rvalid = 1'b1; ram_rdata = 32'hCAFEF00D; #1;
    chk("mbd_done_stall", 32'(stall), 32'd0);
    chk("mbd_done_rdata", cpu_rdata, 32'hCAFEF00D);
    @(negedge clk); setCpu(1'b0, 1'b0, 32'h0, 32'h0); ram_rvalid = 1'b0; #1;
    chk("mbd_after_stall", 32'(stall), 32'd0);

    // reset while a read request is in flight
    @(negedge clk); setCpu(1'b1, 1'b0, 32'h70, 32'h7); #1;
    chk("rmid_st_stall", 32'(stall), 32'd0);
    @(negedge clk); setCpu(1'b0, 1'b1, 32'h80, 32'h0); #1;
    chk("rmid_miss_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("rmid_rd_req", 32'(ram_req), 32'd1);
    chk("rmid_rd_addr", ram_addr, 32'h80);
    #1; rst = 1'b1; #1;
    chk("rmid_req", 32'(ram_req), 32'd0);
    chk("rmid_we", 32'(ram_we), 32'd0);
    chk("rmid_addr", ram_addr, 32'h0);
    chk("rmid_wdata", ram_wdata, 32'h0);
    chk("rmid_stall", 32'(stall), 32'd0);
    chk("rmid_rdata", cpu_rdata, 32'h0);
    chk("rmid_empty", 32'(empty), 32'd1);
    chk("rmid_full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    setCpu(1'b0, 1'b0, 32'h0, 32'h0);
    ram_ready  = 1'b1;
    ram_rvalid = 1'b1;
    ram_rdata  = 32'hDEADBEEF;
    #1;
    chk("rpost_req", 32'(ram_req), 32'd0);
    chk("rpost_rdata", cpu_rdata, 32'h0);
    chk("rpost_stall", 32'(stall), 32'd0);
    chk("rpost_empty", 32'(empty), 32'd1);
    @(negedge clk); #1;
    chk("rpost_idle_req", 32'(ram_req), 32'd0);
    chk("rpost_idle_empty", 32'(empty), 32'd1);
    ram_ready  = 1'b0;
    ram_rvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_store_buffer.md
# data_store_buffer

Posted-write store buffer between the M stage of the pipelined MIPS datapath and the data RAM. Stores (`sw`) retire into a small FIFO without stalling. The FIFO drains to RAM in the background over a req/ready handshake. Loads (`lw`) that hit a buffered address are forwarded from the youngest matching entry; load misses stall the pipeline until RAM returns data.

## Interface
- `DEPTH`, 4: number of buffer entries; power of two, 2..16.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `cpu_wen` input 1: M-stage store request (memWriteM).
- `cpu_ren` input 1: M-stage load request.
- `cpu_addr` input 32: byte address; bits [1:0] ignored (word-only accesses).
- `cpu_wdata` input 32: store data.
- `cpu_rdata` output 32: load data; valid in the cycle `cpu_ren`=1 and `stall`=0.
- `stall` output 1: freeze request for F/D/E/M; the CPU holds all `cpu_*` inputs stable while it is high.
- `empty` output 1: buffer holds no entries.
- `full` output 1: buffer holds DEPTH entries.
- `ram_req` output 1: RAM access request.
- `ram_we` output 1: 1 = write, 0 = read.
- `ram_addr` output 32: word address, formed as {addr[31:2],2'b00}.
- `ram_wdata` output 32: write data.
- `ram_ready` input 1: RAM accepts the request this cycle.
- `ram_rvalid` input 1: read data valid (reads only; writes complete on `ram_ready`).
- `ram_rdata` input 32: read data.

## Operation
- Storage: circular FIFO of {addr[31:2], data}, with head/tail pointers and a count of width clog2(DEPTH)+1. No coalescing; duplicate addresses occupy separate entries.
- Request priority:
  - `cpu_wen` and `cpu_ren` both high: treated as a store only.
  - Neither high: no CPU action.
- Store:
  - Not full: enqueue at tail in this cycle, `stall`=0.
  - Full: `stall`=1 and no enqueue. This holds even if a pop happens in the same cycle; the store enqueues the cycle after count drops.
- Load hit: compare addr[31:2] against all valid entries.
  - Any match: `cpu_rdata` = data of the youngest match (the entry closest to tail), combinationally, with `stall`=0.
  - The entry currently being drained still counts as a match until it is popped.
- Load miss: `stall`=1 until read data returns. The RAM read uses `cpu_addr`, which is held stable by the stall.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT.
  - IDLE:
    - Load miss present: go to RD_REQ.
    - Else if not empty: go to WR_REQ.
    - Otherwise stay in IDLE.
    - `ram_req`=0 in IDLE.
  - WR_REQ:
    - Drive `ram_req`=1, `ram_we`=1, and the head entry's addr/data.
    - Outputs stay stable until `ram_ready`.
    - On `ram_ready`: pop the head and go to IDLE. There is one idle cycle between consecutive drains.
  - RD_REQ:
    - Drive `ram_req`=1, `ram_we`=0, `ram_addr` from `cpu_addr`.
    - On `ram_ready`: go to RD_WAIT.
  - RD_WAIT:
    - `ram_req`=0.
    - On `ram_rvalid`: `cpu_rdata`=`ram_rdata`, `stall`=0 in that same cycle, then go to IDLE.
- A load miss that arrives during WR_REQ waits until the write is accepted. The path is then WR_REQ → IDLE → RD_REQ.
- Simultaneous enqueue (not full) and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- `cpu_rdata` is 0 whenever no load is being answered.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE, head = tail = count = 0, all entries invalid.
  - `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `stall`=0, `cpu_rdata`=0, `empty`=1, `full`=0.
- Reset while a RAM request is in flight: the request is abandoned; any late `ram_rvalid` or `ram_ready` is ignored in IDLE.
- Store into a non-full buffer: 0 stall cycles.
- Load hit: 0 stall cycles.
- Load miss from IDLE with `ram_ready` and `ram_rvalid` immediate: 2 stall cycles.
  - Cycle 0: IDLE, miss detected.
  - Cycle 1: RD_REQ.
  - Cycle 2: RD_WAIT with `rvalid`, `stall`=0.
  - Each wait cycle on `ram_ready` or `ram_rvalid` adds 1 stall cycle.
- Drain throughput: 1 entry per 2 cycles when `ram_ready` is constant 1.
- `empty` and `full` reflect the registered count.

## Test plan
- Reset then idle: `rst`=1 mid-run → all outputs at their reset values within the same cycle; after release `empty`=1, `ram_req`=0.
- Sequence and drain: sw 0x10←0xAAAA0001, sw 0x14←0x0000BEEF, `ram_ready`=1 → `stall`=0 on both stores; RAM sees writes in order to 0x10 then 0x14; `empty`=1 four cycles after the last store.
- Forwarding: `ram_ready`=0, sw 0x20←1, sw 0x20←2, lw 0x22 → `cpu_rdata`=2, `stall`=0, no RAM read issued.
- Load miss: empty buffer, lw 0x40, `ram_rdata`=0x12345678, `ram_rvalid` one cycle after accept → `stall` high for exactly 2 cycles, `cpu_rdata`=0x12345678 in the release cycle.
- Full: DEPTH=4, `ram_ready`=0, five stores → fifth store stalls with `full`=1; raise `ram_ready` → first entry pops, fifth store enqueues the following cycle, no entry is lost or duplicated.
- Load miss behind drain: one buffered store to 0x50, `ram_ready` held 0 for 3 cycles, lw 0x60 → write to 0x50 is accepted first, then read 0x60 is issued; `stall` stays high until `ram_rvalid`.
